uctl_tokendecoder: RTL and testbench

- Rx-path token stage in the USB device controller. Sits between the SIE byte-stream packet receiver (upstream) and the protocol/endpoint controller (downstream).
- Collects the 3-byte token packets OUT, IN, SETUP and SOF. Validates the PID complement and the CRC5 using the existing combinational generator uctl_crc5Gen.
- Presents decoded addr/endp or frame number as registered one-cycle strobes. Counts errors.

---
 rtl/uctl_pkg.sv | 39 +++
 rtl/uctl_crc5Gen.sv | 23 ++
 rtl/uctl_tokendecoder.sv | 204 ++++++++++++++++++++
 tb/tb_uctl_tokendecoder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uctl_pkg.sv
// Shared constants for the USB token decoder: PID codes, FSM encoding, token field layout.
package uctl_pkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_SETUP = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BYTE1 = 2'd1,
      ST_BYTE2 = 2'd2,
      ST_DRAIN = 2'd3
   } tok_state_t;

   // 11-bit field F = {byte2[2:0], byte1}; CRC5 sits in byte2[7:3].
   localparam int FIELD_W  = 11;
   localparam int ADDR_LSB = 0;
   localparam int ADDR_W   = 7;
   localparam int ENDP_LSB = 7;
   localparam int ENDP_W   = 4;
   localparam int B2_F_W   = 3;
   localparam int CRC_LSB  = 3;
   localparam int CRC5_W   = 5;

   function automatic logic is_token_pid(input logic [3:0] pid);
      return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SOF) || (pid == PID_SETUP);
   endfunction

   function automatic logic [CRC5_W-1:0] bitrev5(input logic [CRC5_W-1:0] v);
      logic [CRC5_W-1:0] r;
      r = '0;
      for (int i = 0; i < CRC5_W; i++) begin
         r[i] = v[CRC5_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/uctl_crc5Gen.sv
// Combinational USB CRC5 (x^5+x^2+1, preset all-ones) over the 11-bit token field, LSB first.
// crc_out is the raw remainder; the wire value is bit-reverse(~crc_out).
module uctl_crc5Gen
   import uctl_pkg::*;
(
   input  logic [FIELD_W-1:0] data_in,
   output logic [CRC5_W-1:0]  crc_out
);

   logic [CRC5_W-1:0] crc;
   logic              fb;

   always_comb begin
      crc = '1;
      fb  = 1'b0;
      for (int i = 0; i < FIELD_W; i++) begin
         fb  = data_in[i] ^ crc[CRC5_W-1];
         crc = {crc[CRC5_W-2:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      end
      crc_out = crc;
   end

endmodule

// File: rtl/uctl_tokendecoder.sv
// USB Rx token stage: collects OUT/IN/SETUP/SOF packets, checks PID and CRC5, strobes results.
// Optional device-address filter for OUT/IN/SETUP: define UCTL_TOKEN_ADDR_FILTER_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a PID byte (rxValid & rxSop)
// ST_BYTE1 | token PID accepted, waiting for byte1 (field low byte)
// ST_BYTE2 | waiting for byte2 (field high bits + CRC5), expects rxEop
// ST_DRAIN | discarding the rest of a rejected packet until rxEop
module uctl_tokendecoder
   import uctl_pkg::*;
#(
   parameter int CHECK_PID = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 coreClk,
   input  logic                 coreRst,
   input  logic [7:0]           rxData,
   input  logic                 rxValid,
   input  logic                 rxSop,
   input  logic                 rxEop,
   input  logic                 rxAbort,
   input  logic [6:0]           devAddr,
   output logic                 tokValid,
   output logic                 sofValid,
   output logic [3:0]           tokPid,
   output logic [6:0]           tokAddr,
   output logic [3:0]           tokEndp,
   output logic [10:0]          tokFrameNum,
   output logic                 crcErr,
   output logic                 pidErr,
   output logic                 lenErr,
   output logic [ERR_CNT_W-1:0] errCnt,
   output logic                 busy
);

   tok_state_t state_q, state_d;
   logic [3:0]  pid_q, pid_d;
   logic [7:0]  byte1_q, byte1_d;

   logic        tok_valid_q, tok_valid_d;
   logic        sof_valid_q, sof_valid_d;
   logic        crc_err_q, crc_err_d;
   logic        pid_err_q, pid_err_d;
   logic        len_err_q, len_err_d;
   logic [3:0]  tok_pid_q, tok_pid_d;
   logic [6:0]  tok_addr_q, tok_addr_d;
   logic [3:0]  tok_endp_q, tok_endp_d;
   logic [10:0] tok_frame_q, tok_frame_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [3:0]         rx_pid;
   logic               pid_ok;
   logic [FIELD_W-1:0] field;
   logic [CRC5_W-1:0]  crc_calc;
   logic [CRC5_W-1:0]  crc_rx;
   logic               crc_ok;
   logic               addr_hit;
   logic               err_any;

   assign rx_pid = rxData[3:0];
   assign pid_ok = (CHECK_PID == 0) || (rxData[7:4] == ~rxData[3:0]);
   assign field  = {rxData[B2_F_W-1:0], byte1_q};
   assign crc_rx = rxData[CRC_LSB +: CRC5_W];
   assign crc_ok = (crc_rx == bitrev5(~crc_calc));

`ifdef UCTL_TOKEN_ADDR_FILTER_EN
   assign addr_hit = (field[ADDR_LSB +: ADDR_W] == devAddr);
`else
   logic unused_dev_addr;
   assign unused_dev_addr = ^devAddr;
   assign addr_hit        = 1'b1;
`endif

   uctl_crc5Gen u_crc5 (
      .data_in (field),
      .crc_out (crc_calc)
   );

   always_comb begin
      state_d     = state_q;
      pid_d       = pid_q;
      byte1_d     = byte1_q;
      tok_valid_d = 1'b0;
      sof_valid_d = 1'b0;
      crc_err_d   = 1'b0;
      pid_err_d   = 1'b0;
      len_err_d   = 1'b0;
      tok_pid_d   = tok_pid_q;
      tok_addr_d  = tok_addr_q;
      tok_endp_d  = tok_endp_q;
      tok_frame_d = tok_frame_q;

      if (rxAbort) begin
         state_d = ST_IDLE;
      end else if (rxValid) begin
         if (rxSop) begin
            // A new PID cuts short any token in flight; the old one is reported as a length error.
            len_err_d = (state_q == ST_BYTE1) || (state_q == ST_BYTE2);
            state_d   = ST_IDLE;
            if (is_token_pid(rx_pid)) begin
               if (!pid_ok) begin
                  pid_err_d = !len_err_d;
                  state_d   = rxEop ? ST_IDLE : ST_DRAIN;
               end else if (rxEop) begin
                  len_err_d = 1'b1;
               end else begin
                  pid_d   = rx_pid;
                  state_d = ST_BYTE1;
               end
            end
         end else begin
            case (state_q)
               ST_BYTE1: begin
                  byte1_d = rxData;
                  if (rxEop) begin
                     len_err_d = 1'b1;
                     state_d   = ST_IDLE;
                  end else begin
                     state_d = ST_BYTE2;
                  end
               end
               ST_BYTE2: begin
                  if (rxEop) begin
                     state_d = ST_IDLE;
                     if (!crc_ok) begin
                        crc_err_d = 1'b1;
                     end else if (pid_q == PID_SOF) begin
                        sof_valid_d = 1'b1;
                        tok_pid_d   = pid_q;
                        tok_frame_d = field;
                     end else if (addr_hit) begin
                        tok_valid_d = 1'b1;
                        tok_pid_d   = pid_q;
                        tok_addr_d  = field[ADDR_LSB +: ADDR_W];
                        tok_endp_d  = field[ENDP_LSB +: ENDP_W];
                     end
                  end else begin
                     len_err_d = 1'b1;
                     state_d   = ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  if (rxEop) begin
                     state_d = ST_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end

      err_any   = crc_err_d | pid_err_d | len_err_d;
      err_cnt_d = err_cnt_q;
      if (err_any && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge coreClk or posedge coreRst) begin
      if (coreRst) begin
         state_q     <= ST_IDLE;
         pid_q       <= '0;
         byte1_q     <= '0;
         tok_valid_q <= 1'b0;
         sof_valid_q <= 1'b0;
         crc_err_q   <= 1'b0;
         pid_err_q   <= 1'b0;
         len_err_q   <= 1'b0;
         tok_pid_q   <= '0;
         tok_addr_q  <= '0;
         tok_endp_q  <= '0;
         tok_frame_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         pid_q       <= pid_d;
         byte1_q     <= byte1_d;
         tok_valid_q <= tok_valid_d;
         sof_valid_q <= sof_valid_d;
         crc_err_q   <= crc_err_d;
         pid_err_q   <= pid_err_d;
         len_err_q   <= len_err_d;
         tok_pid_q   <= tok_pid_d;
         tok_addr_q  <= tok_addr_d;
         tok_endp_q  <= tok_endp_d;
         tok_frame_q <= tok_frame_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign tokValid    = tok_valid_q;
   assign sofValid    = sof_valid_q;
   assign crcErr      = crc_err_q;
   assign pidErr      = pid_err_q;
   assign lenErr      = len_err_q;
   assign tokPid      = tok_pid_q;
   assign tokAddr     = tok_addr_q;
   assign tokEndp     = tok_endp_q;
   assign tokFrameNum = tok_frame_q;
   assign errCnt      = err_cnt_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uctl_tokendecoder.sv
// Scoreboard bench for uctl_tokendecoder; honours UCTL_TOKEN_ADDR_FILTER_EN when defined.
module tb_uctl_tokendecoder;

   logic        coreClk = 1'b0;
   logic        coreRst = 1'b1;
   logic [7:0]  rxData  = '0;
   logic        rxValid = 1'b0;
   logic        rxSop   = 1'b0;
   logic        rxEop   = 1'b0;
   logic        rxAbort = 1'b0;
   logic [6:0]  devAddr = 7'd5;
   logic        tokValid, sofValid, crcErr, pidErr, lenErr, busy;
   logic [3:0]  tokPid, tokEndp;
   logic [6:0]  tokAddr;
   logic [10:0] tokFrameNum;
   logic [7:0]  errCnt;

   int n_tests = 0;
   int n_fail  = 0;

   uctl_tokendecoder dut (
      .coreClk(coreClk), .coreRst(coreRst), .rxData(rxData), .rxValid(rxValid),
      .rxSop(rxSop), .rxEop(rxEop), .rxAbort(rxAbort), .devAddr(devAddr),
      .tokValid(tokValid), .sofValid(sofValid), .tokPid(tokPid), .tokAddr(tokAddr),
      .tokEndp(tokEndp), .tokFrameNum(tokFrameNum), .crcErr(crcErr), .pidErr(pidErr),
      .lenErr(lenErr), .errCnt(errCnt), .busy(busy)
   );

   always #5 coreClk = ~coreClk;

   localparam logic [4:0] S_TOK = 5'b10000;
   localparam logic [4:0] S_SOF = 5'b01000;
   localparam logic [4:0] S_CRC = 5'b00100;
   localparam logic [4:0] S_PID = 5'b00010;
   localparam logic [4:0] S_LEN = 5'b00001;

   typedef struct packed {
      logic [4:0]  strb;
      logic [3:0]  pid;
      logic [6:0]  addr;
      logic [3:0]  endp;
      logic [10:0] frame;
      logic [7:0]  errc;
   } exp_t;

   exp_t exp_q[$];
   logic [3:0]  m_pid;
   logic [6:0]  m_addr;
   logic [3:0]  m_endp;
   logic [10:0] m_frame;
   logic [7:0]  m_err;

   // Reflected-register CRC5: returns the 5-bit value as it sits in byte2[7:3].
   function automatic logic [4:0] crc_field(input logic [10:0] f);
      logic [4:0] r;
      logic       fb;
      r = 5'h1F;
      for (int i = 0; i < 11; i++) begin
         fb = f[i] ^ r[0];
         r  = r >> 1;
         if (fb) r = r ^ 5'b10100;
      end
      return ~r;
   endfunction

   function automatic void model_reset();
      m_pid = '0; m_addr = '0; m_endp = '0; m_frame = '0; m_err = '0;
      exp_q.delete();
   endfunction

   function automatic void push_cur(input logic [4:0] strb);
      exp_t e;
      e.strb = strb; e.pid = m_pid; e.addr = m_addr; e.endp = m_endp;
      e.frame = m_frame; e.errc = m_err;
      exp_q.push_back(e);
   endfunction

   function automatic void push_err(input logic [4:0] strb);
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      push_cur(strb);
   endfunction

   function automatic void push_good(input logic [3:0] pid4, input logic [10:0] f);
      if (pid4 == 4'h5) begin
         m_pid = pid4; m_frame = f;
         push_cur(S_SOF);
      end else begin
`ifdef UCTL_TOKEN_ADDR_FILTER_EN
         if (f[6:0] != devAddr) return;
`endif
         m_pid = pid4; m_addr = f[6:0]; m_endp = f[10:7];
         push_cur(S_TOK);
      end
   endfunction

   logic [4:0] obs;
   exp_t       e_mon;
   always @(posedge coreClk) begin
      #1;
      obs = {tokValid, sofValid, crcErr, pidErr, lenErr};
      if (!coreRst && obs != 5'b0) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe got %b required none at %0t", obs, $time);
         end else begin
            e_mon = exp_q.pop_front();
            if ({obs, tokPid, tokAddr, tokEndp, tokFrameNum, errCnt} !== e_mon) begin
               n_fail++;
               $display("FAIL sb_event got strb=%b pid=%h addr=%0d endp=%0d frame=%0d err=%0d required strb=%b pid=%h addr=%0d endp=%0d frame=%0d err=%0d",
                        obs, tokPid, tokAddr, tokEndp, tokFrameNum, errCnt,
                        e_mon.strb, e_mon.pid, e_mon.addr, e_mon.endp, e_mon.frame, e_mon.errc);
            end
         end
      end
   end

   task automatic drv(input logic [7:0] d, input logic sop, input logic eop, input logic abort);
      @(negedge coreClk);
      rxValid = 1'b1; rxData = d; rxSop = sop; rxEop = eop; rxAbort = abort;
   endtask

   task automatic gap(input int n);
      @(negedge coreClk);
      rxValid = 1'b0; rxSop = 1'b0; rxEop = 1'b0; rxAbort = 1'b0;
      repeat (n - 1) @(negedge coreClk);
   endtask

   task automatic send_tok(input logic [3:0] pid4, input logic [10:0] f, input logic bad);
      logic [4:0] c;
      c = crc_field(f);
      if (bad) c = c ^ 5'b00001;
      drv({~pid4, pid4}, 1'b1, 1'b0, 1'b0);
      drv(f[7:0], 1'b0, 1'b0, 1'b0);
      drv({c, f[10:8]}, 1'b0, 1'b1, 1'b0);
      if (bad) push_err(S_CRC);
      else     push_good(pid4, f);
   endtask

   task automatic settle(input string name);
      gap(4);
      n_tests++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_settle pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      coreRst = 1'b1;
      model_reset();
      repeat (3) @(negedge coreClk);
      n_tests++;
      if ({tokValid, sofValid, crcErr, pidErr, lenErr, busy, tokPid, tokAddr, tokEndp, tokFrameNum, errCnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got strb=%b busy=%b pid=%h addr=%h endp=%h frame=%h err=%h required all zero",
                  {tokValid, sofValid, crcErr, pidErr, lenErr}, busy, tokPid, tokAddr, tokEndp, tokFrameNum, errCnt);
      end
      coreRst = 1'b0;
      @(negedge coreClk);
   endtask

   task automatic test_setup_literal();
      drv(8'h2D, 1'b1, 1'b0, 1'b0);
      drv(8'h00, 1'b0, 1'b0, 1'b0);
      drv(8'h10, 1'b0, 1'b1, 1'b0);
      m_pid = 4'hD; m_addr = 7'd0; m_endp = 4'd0;
      push_cur(S_TOK);
      gap(1);
      n_tests++;
      if (tokPid !== 4'hD || tokAddr !== 7'd0 || tokEndp !== 4'd0 || errCnt !== 8'd0) begin
         n_fail++;
         $display("FAIL setup_fields got pid=%h addr=%0d endp=%0d err=%0d required pid=d addr=0 endp=0 err=0",
                  tokPid, tokAddr, tokEndp, errCnt);
      end
      settle("setup");
      send_tok(4'h9, 11'h1A5, 1'b0);
      settle("in_nonzero");
   endtask

   task automatic test_crc_err();
      drv(8'h2D, 1'b1, 1'b0, 1'b0);
      drv(8'h00, 1'b0, 1'b0, 1'b0);
      drv(8'h18, 1'b0, 1'b1, 1'b0);
      push_err(S_CRC);
      settle("crc_literal");
      send_tok(4'h5, 11'h3F0, 1'b1);
      settle("crc_sof");
   endtask

   task automatic test_pid_err();
      drv(8'h3D, 1'b1, 1'b0, 1'b0);
      push_err(S_PID);
      drv(8'h00, 1'b0, 1'b0, 1'b0);
      drv(8'h10, 1'b0, 1'b1, 1'b0);
      settle("pid_err");
      drv(8'h2C, 1'b1, 1'b0, 1'b0);
      drv(8'h00, 1'b0, 1'b0, 1'b0);
      drv(8'h10, 1'b0, 1'b1, 1'b0);
      settle("non_token");
   endtask

   task automatic test_len_err();
      drv(8'h2D, 1'b1, 1'b1, 1'b0);
      push_err(S_LEN);
      settle("len_single");
      drv(8'h2D, 1'b1, 1'b0, 1'b0);
      drv(8'h00, 1'b0, 1'b1, 1'b0);
      push_err(S_LEN);
      settle("len_two");
      drv(8'hE1, 1'b1, 1'b0, 1'b0);
      drv(8'h33, 1'b0, 1'b0, 1'b0);
      push_err(S_LEN);
      send_tok(4'hD, 11'h000, 1'b0);
      settle("sop_in_byte2");
      drv(8'h69, 1'b1, 1'b0, 1'b0);
      drv(8'h12, 1'b0, 1'b0, 1'b0);
      drv(8'h10, 1'b0, 1'b0, 1'b0);
      push_err(S_LEN);
      drv(8'hAA, 1'b0, 1'b0, 1'b0);
      drv(8'hBB, 1'b0, 1'b1, 1'b0);
      settle("len_long_drain");
      drv(8'h69, 1'b1, 1'b0, 1'b0);
      drv(8'h12, 1'b0, 1'b0, 1'b0);
      drv(8'h10, 1'b0, 1'b0, 1'b0);
      push_err(S_LEN);
      drv(8'hAA, 1'b0, 1'b0, 1'b0);
      send_tok(4'h1, 11'h2C7, 1'b0);
      settle("sop_in_drain");
   endtask

   task automatic test_abort();
      drv(8'h2D, 1'b1, 1'b0, 1'b0);
      drv(8'h00, 1'b0, 1'b0, 1'b0);
      drv(8'h10, 1'b0, 1'b1, 1'b1);
      gap(1);
      n_tests++;
      if (busy !== 1'b0 || errCnt !== m_err) begin
         n_fail++;
         $display("FAIL abort got busy=%b err=%0d required busy=0 err=%0d", busy, errCnt, m_err);
      end
      settle("abort");
   endtask

   task automatic test_gaps();
      logic [4:0] c;
      c = crc_field(11'h4D2);
      drv(8'h69, 1'b1, 1'b0, 1'b0);
      gap(3);
      drv(8'hD2, 1'b0, 1'b0, 1'b0);
      gap(2);
      drv({c, 3'b100}, 1'b0, 1'b1, 1'b0);
      push_good(4'h9, 11'h4D2);
      settle("gaps");
   endtask

   task automatic test_random();
      logic [3:0]  pids [4];
      logic [10:0] f;
      pids[0] = 4'h1; pids[1] = 4'h9; pids[2] = 4'h5; pids[3] = 4'hD;
      for (int i = 0; i < 12; i++) begin
         f = 11'($urandom_range(0, 2047));
         send_tok(pids[$urandom_range(0, 3)], f, ($urandom_range(0, 3) == 0));
         gap(1);
      end
      settle("random");
   endtask

   task automatic test_back_to_back();
      send_tok(4'h1, 11'h085, 1'b0);
      send_tok(4'h5, 11'h7FF, 1'b0);
      send_tok(4'h9, 11'h005, 1'b1);
      send_tok(4'hD, 11'h385, 1'b0);
      settle("back_to_back");
   endtask

   task automatic test_addr_filter();
      devAddr = 7'd5;
      send_tok(4'h9, {4'd2, 7'd5}, 1'b0);
      settle("filter_hit");
      send_tok(4'h9, {4'd1, 7'd3}, 1'b0);
      settle("filter_miss");
      send_tok(4'h5, 11'h123, 1'b0);
      settle("filter_sof");
   endtask

   task automatic test_reset_midpacket();
      drv(8'h2D, 1'b1, 1'b0, 1'b0);
      gap(1);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_busy_before got %b required 1", busy);
      end
      coreRst = 1'b1;
      model_reset();
      @(negedge coreClk);
      n_tests++;
      if (busy !== 1'b0 || errCnt !== 8'd0 || tokPid !== 4'h0) begin
         n_fail++;
         $display("FAIL midrst_state got busy=%b err=%0d pid=%h required busy=0 err=0 pid=0", busy, errCnt, tokPid);
      end
      coreRst = 1'b0;
      drv(8'h00, 1'b0, 1'b0, 1'b0);
      drv(8'h10, 1'b0, 1'b1, 1'b0);
      settle("midrst");
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) begin
         send_tok(4'h1, 11'(i), 1'b1);
      end
      settle("saturate");
      n_tests++;
      if (errCnt !== 8'hFF) begin
         n_fail++;
         $display("FAIL saturate_errcnt got %0d required 255", errCnt);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_setup_literal();
      test_crc_err();
      test_pid_err();
      test_len_err();
      test_abort();
      test_gaps();
      test_random();
      test_back_to_back();
      test_addr_filter();
      test_reset_midpacket();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
